// File: rtl/count_bcd_display_pkg.sv
// Shared definitions for count_bcd_display: FSM states, 7-segment glyphs
// (active-low {g,f,e,d,c,b,a}) and active-low anode-select patterns.
package count_bcd_display_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [2:0] SEL_ONES = 3'b110;
  localparam logic [2:0] SEL_TENS = 3'b101;
  localparam logic [2:0] SEL_HUND = 3'b011;

  function automatic logic [2:0] sel_pattern(input logic [1:0] idx);
    case (idx)
      2'd1:    sel_pattern = SEL_TENS;
      2'd2:    sel_pattern = SEL_HUND;
      default: sel_pattern = SEL_ONES;
    endcase
  endfunction

  // Double-dabble correction applied to each BCD nibble before the shift.
  function automatic logic [3:0] add3(input logic [3:0] n);
    add3 = (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/count_bcd_display_seg7_decode.sv
// seg7_decode: combinational BCD nibble to active-low 7-segment pattern.
// Codes A-F never come from the converter and are shown as blank.
module seg7_decode
  import count_bcd_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/count_bcd_display.sv
// count_bcd_display: samples an 8-bit count, converts it to BCD with a
// sequential double-dabble engine and scans a 3-digit common-anode display.
// Optional build macro SEG_BLANK_LEADING_EN blanks leading-zero digits.
//
// state | meaning
// IDLE  | waiting for load; bcd holds the last result
// CONV  | one double-dabble iteration per cycle, 8 in total
module count_bcd_display
  import count_bcd_display_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  count,
  input  logic        load,
  output logic        busy,
  output logic [11:0] bcd,
  output logic [2:0]  digit_sel,
  output logic [6:0]  seg
);

  localparam int PW = $clog2(SCAN_DIV);

  state_t      state, state_n;
  logic [7:0]  sr;
  logic [11:0] acc;
  logic [2:0]  iter;
  logic [11:0] adj;
  logic [19:0] shifted;

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [3:0]    nibble;
  logic [6:0]    seg_dec;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (load) state_n = CONV;
      CONV: if (iter == 3'd7) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == CONV);

  always_comb begin
    adj     = {add3(acc[11:8]), add3(acc[7:4]), add3(acc[3:0])};
    shifted = {adj, sr} << 1;
  end

  // The result is committed from the final shift so bcd never shows partials.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr   <= '0;
      acc  <= '0;
      iter <= '0;
      bcd  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            sr   <= count;
            acc  <= '0;
            iter <= '0;
          end
        end
        CONV: begin
          acc  <= shifted[19:8];
          sr   <= shifted[7:0];
          iter <= iter + 3'd1;
          if (iter == 3'd7) bcd <= shifted[19:8];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc <= '0;
      idx   <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Blanked digits are steered to an unused code, which decodes to blank.
  always_comb begin
    case (idx)
      2'd1:    nibble = bcd[7:4];
      2'd2:    nibble = bcd[11:8];
      default: nibble = bcd[3:0];
    endcase
`ifdef SEG_BLANK_LEADING_EN
    if (idx == 2'd2 && bcd[11:8] == 4'd0)
      nibble = 4'hF;
    if (idx == 2'd1 && bcd[11:4] == 8'd0)
      nibble = 4'hF;
`endif
  end

  seg7_decode u_dec (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_sel <= SEL_ONES;
      seg       <= SEG_0;
    end else begin
      digit_sel <= sel_pattern(idx);
      seg       <= seg_dec;
    end
  end

endmodule

// File: tb/tb_count_bcd_display.sv
// Self-checking bench for count_bcd_display with SCAN_DIV = 4.
module tb_count_bcd_display;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [7:0]  count;
  logic        busy;
  logic [11:0] bcd;
  logic [2:0]  digit_sel;
  logic [6:0]  seg;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G6 = 7'b0000010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] G9 = 7'b0010000;
`ifdef SEG_BLANK_LEADING_EN
  localparam logic [6:0] LZ = 7'b1111111;
`else
  localparam logic [6:0] LZ = 7'b1000000;
`endif

  typedef struct {
    logic [7:0]  cnt;
    logic [11:0] exp_bcd;
    logic [6:0]  s_ones;
    logic [6:0]  s_tens;
    logic [6:0]  s_hund;
  } vec_t;

  vec_t vecs [8];

  count_bcd_display #(.SCAN_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .count     (count),
    .load      (load),
    .busy      (busy),
    .bcd       (bcd),
    .digit_sel (digit_sel),
    .seg       (seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Strobe load for one cycle, check busy window and bcd stability, end after N+8.
  task automatic convert(input logic [7:0] c, input logic [11:0] exp);
    logic [11:0] prev;
    @(negedge clk);
    prev  = bcd;
    count = c;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("busy during conv of %0d cycle %0d", c, k), 32'(busy), 32'd1);
      check($sformatf("bcd held during conv of %0d", c), 32'(bcd), 32'(prev));
      @(negedge clk);
    end
    check($sformatf("busy done for %0d", c), 32'(busy), 32'd0);
    check($sformatf("bcd result for %0d", c), 32'(bcd), 32'(exp));
  endtask

  // Observe one full frame (12 cycles) and check glyphs, order and dwell.
  task automatic scan_check(input vec_t v);
    int n_o, n_t, n_h;
    logic [2:0] prev_sel;
    logic [2:0] succ;
    n_o = 0; n_t = 0; n_h = 0;
    @(negedge clk);
    prev_sel = digit_sel;
    for (int k = 0; k < 12; k++) begin
      case (digit_sel)
        3'b110: begin n_o++; check($sformatf("seg ones for %0d", v.cnt), 32'(seg), 32'(v.s_ones)); end
        3'b101: begin n_t++; check($sformatf("seg tens for %0d", v.cnt), 32'(seg), 32'(v.s_tens)); end
        3'b011: begin n_h++; check($sformatf("seg hund for %0d", v.cnt), 32'(seg), 32'(v.s_hund)); end
        default: begin
          n_checks++; n_fail++;
          $display("FAIL digit_sel legal: got %b, expected one-hot-low", digit_sel);
        end
      endcase
      if (digit_sel !== prev_sel) begin
        case (prev_sel)
          3'b110:  succ = 3'b101;
          3'b101:  succ = 3'b011;
          default: succ = 3'b110;
        endcase
        check("digit_sel order", 32'(digit_sel), 32'(succ));
      end
      prev_sel = digit_sel;
      @(negedge clk);
    end
    check("ones dwell cycles", 32'(n_o), 32'd4);
    check("tens dwell cycles", 32'(n_t), 32'd4);
    check("hund dwell cycles", 32'(n_h), 32'd4);
  endtask

  initial begin
    vecs[0] = '{8'd255, 12'h255, G5, G5, G2};
    vecs[1] = '{8'd7,   12'h007, G7, LZ, LZ};
    vecs[2] = '{8'd200, 12'h200, G0, G0, G2};
    vecs[3] = '{8'd100, 12'h100, G0, G0, G1};
    vecs[4] = '{8'd0,   12'h000, G0, LZ, LZ};
    vecs[5] = '{8'd99,  12'h099, G9, G9, LZ};
    vecs[6] = '{8'd138, 12'h138, G8, G3, G1};
    vecs[7] = '{8'd64,  12'h064, G4, G6, LZ};

    reset = 1'b1;
    load  = 1'b0;
    count = 8'd0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset bcd", 32'(bcd), 32'h000);
    check("reset digit_sel", 32'(digit_sel), 32'b110);
    check("reset seg", 32'(seg), 32'b1000000);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold busy", 32'(busy), 32'd0);
      check("hold bcd", 32'(bcd), 32'h000);
      check("hold digit_sel", 32'(digit_sel), 32'b110);
      check("hold seg", 32'(seg), 32'b1000000);
    end

    for (int i = 0; i < 8; i++) begin
      convert(vecs[i].cnt, vecs[i].exp_bcd);
      scan_check(vecs[i]);
    end

    // Second strobe three cycles into a conversion is dropped.
    @(negedge clk);
    count = 8'd200; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    count = 8'd9; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("busy during ignored load", 32'(busy), 32'd1);
    repeat (5) @(negedge clk);
    check("ignored load busy N+8", 32'(busy), 32'd0);
    check("ignored load bcd N+8", 32'(bcd), 32'h200);
    @(negedge clk);
    check("ignored load not queued", 32'(busy), 32'd0);
    check("ignored load bcd N+9", 32'(bcd), 32'h200);

    // Load held high: edge N+8 is ignored, edge N+9 is accepted.
    @(negedge clk);
    count = 8'd5; load = 1'b1;
    @(negedge clk);
    count = 8'd9;
    repeat (7) @(negedge clk);
    check("held load busy N+7", 32'(busy), 32'd1);
    @(negedge clk);
    check("held load busy N+8", 32'(busy), 32'd0);
    check("held load bcd N+8", 32'(bcd), 32'h005);
    @(negedge clk);
    load = 1'b0;
    check("back-to-back accepted N+9", 32'(busy), 32'd1);
    repeat (8) @(negedge clk);
    check("back-to-back busy done", 32'(busy), 32'd0);
    check("back-to-back bcd", 32'(bcd), 32'h009);

    // Reset on the 4th CONV cycle aborts the conversion.
    @(negedge clk);
    count = 8'd100; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    check("busy before abort", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort bcd", 32'(bcd), 32'h000);
    convert(8'd100, 12'h100);

    // Reset and load on the same edge: reset wins.
    @(negedge clk);
    reset = 1'b1; load = 1'b1; count = 8'd55;
    @(negedge clk);
    check("reset+load busy", 32'(busy), 32'd0);
    reset = 1'b0; load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("reset+load stays idle", 32'(busy), 32'd0);
      check("reset+load bcd", 32'(bcd), 32'h000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
